// File: rtl/mdu_pkg.sv
// Shared encodings and widths for the multiply/divide sequencing controller.
package mdu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_MULT_WAIT = 2'b01,
    ST_DIV_WAIT  = 2'b10,
    ST_DONE      = 2'b11
  } state_e;

endpackage

// File: rtl/mdu_cycle_counter.sv
// Loadable down-counter with a zero flag; used both for multiplier latency
// and for the divider watchdog. It saturates at zero rather than wrapping.
module mdu_cycle_counter
  import mdu_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/mult_div_ctrl.sv
// Sequences MULT/DIV/MTHI/MTLO requests onto the shared multiplier and the
// iterative divider, owns architectural HI/LO and reports busy/done.
module mult_div_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT    = 2,
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic              timeout,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic [DATA_W-1:0] mult_a,
  output logic [DATA_W-1:0] mult_b,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_low,
  output logic              div_start,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_quot,
  input  logic [DATA_W-1:0] div_rem
);

  state_e           state;
  op_e              op_c;
  logic             accept_c;
  logic             cnt_load_c;
  logic             cnt_dec_c;
  logic             cnt_zero_c;
  logic [CNT_W-1:0] cnt_load_val_c;

  // Counter is loaded only on launches that actually wait on a resource.
  always_comb begin
    op_c           = op_e'(op);
    accept_c       = start && ((state == ST_IDLE) || (state == ST_DONE));
    cnt_load_c     = 1'b0;
    cnt_load_val_c = CNT_W'(DIV_TIMEOUT - 1);
    cnt_dec_c      = (state == ST_MULT_WAIT) || (state == ST_DIV_WAIT);
    if (accept_c && (op_c == OP_MULT)) begin
      cnt_load_c     = 1'b1;
      cnt_load_val_c = CNT_W'(MULT_LAT - 1);
    end else if (accept_c && (op_c == OP_DIV) && (rt_val != '0)) begin
      cnt_load_c = 1'b1;
    end
  end

  mdu_cycle_counter u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load_c),
    .load_val (cnt_load_val_c),
    .dec      (cnt_dec_c),
    .zero_c   (cnt_zero_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      timeout   <= 1'b0;
      div_start <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
      mult_a    <= '0;
      mult_b    <= '0;
      div_a     <= '0;
      div_b     <= '0;
    end else begin
      done      <= 1'b0;
      div_start <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (accept_c) begin
            div_zero <= 1'b0;
            timeout  <= 1'b0;
            case (op_c)
              OP_MULT: begin
                mult_a <= rs_val;
                mult_b <= rt_val;
                busy   <= 1'b1;
                state  <= ST_MULT_WAIT;
              end
              OP_DIV: begin
                if (rt_val == '0) begin
                  div_zero <= 1'b1;
                  done     <= 1'b1;
                  state    <= ST_DONE;
                end else begin
                  div_a     <= rs_val;
                  div_b     <= rt_val;
                  div_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ST_DIV_WAIT;
                end
              end
              OP_MTHI: begin
                hi_out <= rs_val;
                done   <= 1'b1;
                state  <= ST_DONE;
              end
              OP_MTLO: begin
                lo_out <= rs_val;
                done   <= 1'b1;
                state  <= ST_DONE;
              end
            endcase
          end
        end
        // The multiplier names its ports backwards: "low" carries the upper word.
        ST_MULT_WAIT: begin
          if (cnt_zero_c) begin
            hi_out <= mult_low;
            lo_out <= mult_hi;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        // A div_done seen alongside our own launch pulse is stale and ignored.
        ST_DIV_WAIT: begin
          if (!div_start && div_done) begin
            hi_out <= div_rem;
            lo_out <= div_quot;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else if (cnt_zero_c) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl with a one-stage signed multiplier model
// and an unsigned divider model that answers five cycles after launch.
`timescale 1ns/1ps
module tb_mult_div_ctrl;
  import mdu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy, done, div_zero, timeout, div_start, div_done;
  logic [31:0] hi_out, lo_out, mult_a, mult_b, mult_hi, mult_low;
  logic [31:0] div_a, div_b, div_quot, div_rem;

  logic [63:0] prod_q = '0;
  int          dcnt = 0;
  logic [31:0] qa = '0;
  logic [31:0] qb = 32'd1;
  logic        div_mute = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs, rt, hi, lo;
    logic        dz, to;
    int          lat;
    int          starts;
  } vec_t;

  always #5 clock = ~clock;

  mult_div_ctrl #(.MULT_LAT(2), .DIV_TIMEOUT(64)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
    .div_zero(div_zero), .timeout(timeout), .hi_out(hi_out), .lo_out(lo_out),
    .mult_a(mult_a), .mult_b(mult_b), .mult_hi(mult_hi), .mult_low(mult_low),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_done(div_done),
    .div_quot(div_quot), .div_rem(div_rem)
  );

  always @(posedge clock)
    prod_q <= $signed({{32{mult_a[31]}}, mult_a}) * $signed({{32{mult_b[31]}}, mult_b});
  assign mult_hi  = prod_q[31:0];
  assign mult_low = prod_q[63:32];

  always @(posedge clock) begin
    if (div_start && !div_mute) begin
      dcnt <= 5;
      qa   <= div_a;
      qb   <= div_b;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end
  end
  assign div_done = (dcnt == 1);
  assign div_quot = (qb == '0) ? '1 : qa / qb;
  assign div_rem  = (qb == '0) ? qa : qa % qb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one request, then sample every cycle until done (bounded).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit busy_ok, output bit stable_ok,
                        output int starts);
    int n;
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    step();
    start  = 1'b0;
    rs_val = '0;
    rt_val = '0;
    lat = -1; busy_ok = 1'b1; stable_ok = 1'b1; starts = 0; n = 0;
    while (n <= 200) begin
      if (busy === done) busy_ok = 1'b0;
      if ((o == OP_MULT) && ((mult_a !== a) || (mult_b !== b))) stable_ok = 1'b0;
      if ((o == OP_DIV) && (b != '0) && ((div_a !== a) || (div_b !== b))) stable_ok = 1'b0;
      if (div_start === 1'b1) starts++;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      step();
      n++;
    end
  endtask

  initial begin
    vec_t v[9];
    int   lat, starts;
    bit   bok, sok;
    bit   seen;

    v[0] = '{OP_MTHI, 32'h11,       32'h0,        32'h11,       32'h0,        1'b0, 1'b0, 0, 0};
    v[1] = '{OP_MTLO, 32'h22,       32'h0,        32'h11,       32'h22,       1'b0, 1'b0, 0, 0};
    v[2] = '{OP_DIV,  32'd5,        32'd0,        32'h11,       32'h22,       1'b1, 1'b0, 0, 0};
    v[3] = '{OP_MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, 2, 0};
    v[4] = '{OP_DIV,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0, 6, 1};
    v[5] = '{OP_MULT, 32'h10000,    32'h10000,    32'h1,        32'h0,        1'b0, 1'b0, 2, 0};
    v[6] = '{OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0, 1'b0, 2, 0};
    v[7] = '{OP_DIV,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1'b0, 1'b0, 6, 1};
    v[8] = '{OP_DIV,  32'd9,        32'd0,        32'hF,        32'h0FFFFFFF, 1'b1, 1'b0, 0, 0};

    step();
    step();
    chk("reset busy/done/dz/to/ds", {27'd0, busy, done, div_zero, timeout, div_start}, 32'h0);
    chk("reset hi", hi_out, 32'h0);
    chk("reset lo", lo_out, 32'h0);
    chk("reset mult_a|mult_b|div_a|div_b", mult_a | mult_b | div_a | div_b, 32'h0);
    reset = 1'b1;
    step();

    // Vectors run back to back: each new request is accepted in the DONE cycle.
    for (int i = 0; i < 9; i++) begin
      run_op(v[i].op, v[i].rs, v[i].rt, lat, bok, sok, starts);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(v[i].lat));
      chk($sformatf("v%0d hi", i), hi_out, v[i].hi);
      chk($sformatf("v%0d lo", i), lo_out, v[i].lo);
      chk($sformatf("v%0d div_zero", i), {31'd0, div_zero}, {31'd0, v[i].dz});
      chk($sformatf("v%0d timeout", i), {31'd0, timeout}, {31'd0, v[i].to});
      chk($sformatf("v%0d busy_vs_done", i), {31'd0, bok}, 32'd1);
      chk($sformatf("v%0d operands_stable", i), {31'd0, sok}, 32'd1);
      chk($sformatf("v%0d div_start_pulses", i), 32'(starts), 32'(v[i].starts));
    end

    step();
    step();
    chk("sticky div_zero", {31'd0, div_zero}, 32'd1);
    chk("idle done/busy", {30'd0, done, busy}, 32'd0);

    // Start request during MULT_WAIT must be dropped.
    start = 1'b1; op = OP_MULT; rs_val = 32'd3; rt_val = 32'd5;
    step();
    op = OP_MTHI; rs_val = 32'hAAAA; rt_val = '0;
    chk("ign busy T", {31'd0, busy}, 32'd1);
    step();
    start = 1'b0;
    chk("ign busy T+1", {30'd0, busy, done}, 32'd2);
    chk("ign mult_a held", mult_a, 32'd3);
    step();
    chk("ign done T+2", {30'd0, busy, done}, 32'd1);
    chk("ign hi", hi_out, 32'h0);
    chk("ign lo", lo_out, 32'd15);

    // MTLO then DIV accepted in the DONE cycle.
    run_op(OP_MTLO, 32'h1234, 32'h0, lat, bok, sok, starts);
    chk("b2b mtlo lat", 32'(lat), 32'd0);
    chk("b2b mtlo lo", lo_out, 32'h1234);
    run_op(OP_DIV, 32'd9, 32'd2, lat, bok, sok, starts);
    chk("b2b div lat", 32'(lat), 32'd6);
    chk("b2b div hi", hi_out, 32'd1);
    chk("b2b div lo", lo_out, 32'd4);
    chk("b2b div busy", {31'd0, bok}, 32'd1);

    // Reset while the divider is working; its late div_done must be ignored.
    step();
    start = 1'b1; op = OP_DIV; rs_val = 32'd50; rt_val = 32'd3;
    step();
    start = 1'b0;
    step();
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst busy/done/dz/to/ds", {27'd0, busy, done, div_zero, timeout, div_start}, 32'h0);
    chk("rst hi|lo", hi_out | lo_out, 32'h0);
    chk("rst operand regs", mult_a | mult_b | div_a | div_b, 32'h0);
    step();
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if ((done === 1'b1) || (busy === 1'b1)) seen = 1'b1;
    end
    chk("rst late div_done ignored", {31'd0, seen}, 32'd0);
    chk("rst hi after", hi_out, 32'h0);
    chk("rst lo after", lo_out, 32'h0);

    // Divider never answers: watchdog abort.
    div_mute = 1'b1;
    run_op(OP_DIV, 32'd1, 32'd1, lat, bok, sok, starts);
    chk("to latency", 32'(lat), 32'd64);
    chk("to flag", {31'd0, timeout}, 32'd1);
    chk("to hi|lo unchanged", hi_out | lo_out, 32'h0);
    chk("to div_start pulses", 32'(starts), 32'd1);
    step();
    chk("to sticky", {31'd0, timeout}, 32'd1);
    div_mute = 1'b0;
    run_op(OP_MTHI, 32'h5, 32'h0, lat, bok, sok, starts);
    chk("to cleared by accept", {31'd0, timeout}, 32'd0);
    chk("mthi after to", hi_out, 32'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
Sequencing controller for the CPU's multiply/divide resources. It accepts MULT/DIV/MTHI/MTLO requests from the main control unit and drives the shared fixed-latency multiplier and the iterative divider. It owns the architectural HI/LO registers and presents busy/done handshakes so the control FSM can stall.

Parameters:
MULT_LAT, 2, cycles from operand launch to product capture (multiplier registers one stage internally); legal range 1-15
DIV_TIMEOUT, 64, max cycles waiting for div_done before abort

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request strobe, sampled each rising edge
op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
rs_val  in  32  operand A / MTHI-MTLO source
rt_val  in  32  operand B
busy  out  1  operation in flight; control unit stalls
done  out  1  one-cycle completion pulse
div_zero  out  1  last DIV had rt_val==0 (sticky)
timeout  out  1  last DIV aborted on DIV_TIMEOUT (sticky)
hi_out  out  32  architectural HI
lo_out  out  32  architectural LO
mult_a  out  32  multiplier operand A
mult_b  out  32  multiplier operand B
mult_hi  in  32  multiplier port "hi" = product[31:0]
mult_low  in  32  multiplier port "low" = product[63:32]
div_start  out  1  one-cycle divider launch
div_a  out  32  dividend
div_b  out  32  divisor
div_done  in  1  divider result valid
div_quot  in  32  quotient
div_rem  in  32  remainder

Behaviour:
- Reset (async, reset low): state IDLE; busy, done, div_zero, timeout, div_start = 0; hi_out, lo_out, mult_a/b, div_a/b, counters = 0. Reset mid-operation discards the operation; div_done arriving after reset is ignored.
- States: IDLE, MULT_WAIT, DIV_WAIT, DONE.
- Accept: start sampled high in IDLE or DONE at edge T. start in MULT_WAIT/DIV_WAIT is ignored (no queueing). Each accept clears div_zero and timeout.
- MULT: at T, rs_val/rt_val latched into mult_a/mult_b (held stable until capture); counter = MULT_LAT-1; state MULT_WAIT, busy=1. Counter decrements each edge. At edge T+MULT_LAT: HI <= mult_low, LO <= mult_hi (word swap is mandatory); done=1, busy=0, state DONE.
- DIV, rt_val != 0: at T, div_a/div_b latched, div_start=1 for exactly one cycle, busy=1, timeout counter=0, state DIV_WAIT. At first edge with div_done=1: HI <= div_rem, LO <= div_quot, done=1, busy=0 → DONE. div_done is ignored in the cycle div_start is high.
- DIV, rt_val == 0: no div_start; HI/LO unchanged; div_zero=1; done=1 at T → DONE; busy never asserted.
- DIV timeout: counter reaches DIV_TIMEOUT with no div_done → HI/LO unchanged, timeout=1, done=1 → DONE.
- MTHI/MTLO: at T, HI (resp. LO) <= rs_val; done=1 → DONE; busy never asserted.
- DONE: done high this cycle only. It returns to IDLE, or accepts a new start at the same edge (back-to-back, no bubble).
- busy and done are never high together. hi_out/lo_out change only at capture/MT edges.

Decomposition:
- Shared package mdu_pkg: op encodings (OP_MULT, OP_DIV, OP_MTHI, OP_MTLO) and state encodings.
- One sub-module, mdu_cycle_counter: loadable down-counter with zero flag, reused for MULT_LAT and DIV_TIMEOUT.
- HI/LO registers stay in mult_div_ctrl.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3), multiplier model with MULT_LAT=2 → busy high 2 cycles; done at T+2; HI=0xFFFFFFFF, LO=0xFFFFFFEB; mult_a/b stable throughout.
- DIV rs=100, rt=7, divider model asserts done 5 cycles after div_start → div_start one cycle; HI=2, LO=14; done one cycle after div_done is sampled.
- DIV rs=5, rt=0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO → div_start never high; div_zero=1; HI/LO unchanged; done at T; busy stays 0.
- MULT in flight, start with op=MTHI and rs=0xAAAA during MULT_WAIT → ignored; HI ends as the product upper word, not 0xAAAA.
- Back-to-back: MTLO rs=0x1234, then DIV 9/2 started in the DONE cycle → LO=0x1234 after cycle 1; then LO=4, HI=1; no idle bubble.
- Reset mid-DIV: reset low 3 cycles after div_start, divider model raises div_done after release → all outputs 0, state IDLE, HI/LO remain 0. Separately, divider never responds → timeout=1, done at cycle 64.
